// File: rtl/alu_ez_core_if.sv
// alu_ez_core_if: instruction/operand/result bundle for the decode-and-execute
// stage.
//   master: drives instr, a, b, c and index. Receives the decoded fields and
//           the registered results.
//   slave : the stage itself. Receives instr and the operands. Drives the
//           fields (opcode, dest, op1ad, op2ad, shamt, const6, address) and the
//           registered results (d, dataaddress, reg_write, mem_read, mem_write,
//           next_index).
interface alu_ez_core_if;
  logic [15:0] instr;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic [3:0]  index;
  logic [3:0]  opcode;
  logic [2:0]  dest;
  logic [2:0]  op1ad;
  logic [2:0]  op2ad;
  logic [2:0]  shamt;
  logic [5:0]  const6;
  logic [8:0]  address;
  logic [15:0] d;
  logic [15:0] dataaddress;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  next_index;

  modport master (
    output instr, a, b, c, index,
    input  opcode, dest, op1ad, op2ad, shamt, const6, address,
    input  d, dataaddress, reg_write, mem_read, mem_write, next_index
  );

  modport slave (
    input  instr, a, b, c, index,
    output opcode, dest, op1ad, op2ad, shamt, const6, address,
    output d, dataaddress, reg_write, mem_read, mem_write, next_index
  );
endinterface

// File: rtl/alu_ez_core.sv
// alu_ez_core: decode-and-execute stage of the 16-bit teaching processor.
// Instruction fields are decoded combinationally so that the register file can
// be addressed in the same cycle. The ALU result, the data-memory address, the
// control strobes and the next instruction index are registered.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears every registered output
//   bus   : alu_ez_core_if.slave (instr/a/b/c/index in, fields and results out)
module alu_ez_core (
  input logic         clk,
  input logic         reset,
  alu_ez_core_if.slave bus
);

  assign bus.opcode  = bus.instr[15:12];
  assign bus.dest    = bus.instr[11:9];
  assign bus.op1ad   = bus.instr[8:6];
  assign bus.op2ad   = bus.instr[5:3];
  assign bus.shamt   = bus.instr[2:0];
  assign bus.const6  = bus.instr[5:0];
  assign bus.address = bus.instr[8:0];

  logic [15:0] simm;
  logic [15:0] ea;
  logic [31:0] rot;
  logic [3:0]  seq_index;

  assign simm      = {{10{bus.instr[5]}}, bus.instr[5:0]};
  assign ea        = bus.a + simm;
  // Shifting a doubled copy left puts the rotated word in the upper half.
  assign rot       = {bus.a, bus.a} << bus.instr[2:0];
  assign seq_index = bus.index + 4'd1;

  logic [15:0] d_n;
  logic [15:0] da_n;
  logic [3:0]  ni_n;
  logic        rw_n;
  logic        mr_n;
  logic        mw_n;

  always_comb begin
    d_n  = '0;
    da_n = '0;
    ni_n = seq_index;
    rw_n = 1'b0;
    mr_n = 1'b0;
    mw_n = 1'b0;
    case (bus.instr[15:12])
      4'b0000: begin d_n = bus.a + bus.b;              rw_n = 1'b1; end
      4'b0001: begin d_n = bus.a - bus.b;              rw_n = 1'b1; end
      4'b0010: begin d_n = bus.a & bus.b;              rw_n = 1'b1; end
      4'b0011: begin d_n = bus.a | bus.b;              rw_n = 1'b1; end
      4'b0100: begin d_n = bus.a ^ bus.b;              rw_n = 1'b1; end
      4'b0101: begin d_n = bus.a + simm;               rw_n = 1'b1; end
      4'b0110: begin d_n = {10'd0, bus.instr[5:0]};    rw_n = 1'b1; end
      4'b0111: begin da_n = ea; mr_n = 1'b1;           rw_n = 1'b1; end
      4'b1000: begin da_n = ea; mw_n = 1'b1;                        end
      4'b1001: ni_n = bus.index + bus.instr[3:0];
      4'b1010: begin d_n = bus.a << bus.instr[2:0];    rw_n = 1'b1; end
      4'b1011: begin d_n = bus.a >> bus.instr[2:0];    rw_n = 1'b1; end
      4'b1100: begin d_n = 16'($signed(bus.a) >>> bus.instr[2:0]); rw_n = 1'b1; end
      4'b1101: begin d_n = rot[31:16];                 rw_n = 1'b1; end
      4'b1110: if (bus.a == bus.c) ni_n = bus.instr[3:0];
      4'b1111: if (bus.a != bus.c) ni_n = bus.instr[3:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.d           <= '0;
      bus.dataaddress <= '0;
      bus.reg_write   <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.next_index  <= '0;
    end else begin
      bus.d           <= d_n;
      bus.dataaddress <= da_n;
      bus.reg_write   <= rw_n;
      bus.mem_read    <= mr_n;
      bus.mem_write   <= mw_n;
      bus.next_index  <= ni_n;
    end
  end

endmodule

// File: tb/tb_alu_ez_core.sv
module tb_alu_ez_core;
  logic clk;
  logic reset;
  alu_ez_core_if bus ();

  alu_ez_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] da;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  ni;
  } exp_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [3:0]  index;
    exp_t        e;
  } vec_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  exp_t sb[$];
  vec_t vecs[$];

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] r1, input logic [5:0] lo);
    return {op, rd, r1, lo};
  endfunction

  function automatic exp_t ex(input logic [15:0] d, input logic [15:0] da,
                              input logic rw, input logic mr, input logic mw,
                              input logic [3:0] ni);
    exp_t e;
    e.d = d; e.da = da; e.rw = rw; e.mr = mr; e.mw = mw; e.ni = ni;
    return e;
  endfunction

  function automatic vec_t v(input logic [15:0] instr, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] c,
                             input logic [3:0] index, input exp_t e);
    vec_t r;
    r.instr = instr; r.a = a; r.b = b; r.c = c; r.index = index; r.e = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_regs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".d"},    32'(bus.d),           32'(e.d));
    chk({tag, ".da"},   32'(bus.dataaddress), 32'(e.da));
    chk({tag, ".rw"},   32'(bus.reg_write),   32'(e.rw));
    chk({tag, ".mr"},   32'(bus.mem_read),    32'(e.mr));
    chk({tag, ".mw"},   32'(bus.mem_write),   32'(e.mw));
    chk({tag, ".ni"},   32'(bus.next_index),  32'(e.ni));
  endtask

  task automatic drive(input vec_t t);
    bus.instr = t.instr;
    bus.a     = t.a;
    bus.b     = t.b;
    bus.c     = t.c;
    bus.index = t.index;
  endtask

  initial begin
    // Reset: two clocks with reset low and a live add on the inputs.
    reset = 1'b0;
    drive(v(16'h0000, 16'd5, 16'd3, 16'd0, 4'd0, ex(0, 0, 0, 0, 0, 0)));
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(ex(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0));
    chk_regs("reset");

    // Field decode of the add used in the R-type test.
    @(negedge clk);
    reset = 1'b1;
    drive(v(mk(4'h0, 3'd1, 3'd2, 6'o30), 16'h0007, 16'h001B, 16'h0, 4'd3, ex(0, 0, 0, 0, 0, 0)));
    #1;
    chk("opcode",  32'(bus.opcode),  32'h0);
    chk("dest",    32'(bus.dest),    32'd1);
    chk("op1ad",   32'(bus.op1ad),   32'd2);
    chk("op2ad",   32'(bus.op2ad),   32'd3);
    chk("shamt",   32'(bus.shamt),   32'd0);
    chk("const6",  32'(bus.const6),  32'o30);
    chk("address", 32'(bus.address), 32'h098);

    vecs.push_back(v(mk(4'h0, 3'd1, 3'd2, 6'o30), 16'h0007, 16'h001B, 16'h0, 4'd3, ex(16'h0022, 0, 1, 0, 0, 4'd4)));
    vecs.push_back(v(mk(4'h1, 3'd1, 3'd2, 6'o30), 16'h0007, 16'h001B, 16'h0, 4'd3, ex(16'hFFEC, 0, 1, 0, 0, 4'd4)));
    vecs.push_back(v(mk(4'h2, 3'd1, 3'd2, 6'o30), 16'hF0F0, 16'hFF00, 16'h0, 4'd0, ex(16'hF000, 0, 1, 0, 0, 4'd1)));
    vecs.push_back(v(mk(4'h3, 3'd1, 3'd2, 6'o30), 16'hF0F0, 16'hFF00, 16'h0, 4'd0, ex(16'hFFF0, 0, 1, 0, 0, 4'd1)));
    vecs.push_back(v(mk(4'h4, 3'd1, 3'd2, 6'o30), 16'hF0F0, 16'hFF00, 16'h0, 4'd0, ex(16'h0FF0, 0, 1, 0, 0, 4'd1)));
    vecs.push_back(v(mk(4'h5, 3'd1, 3'd2, 6'h3F), 16'h0004, 16'h0, 16'h0, 4'd5, ex(16'h0003, 0, 1, 0, 0, 4'd6)));
    vecs.push_back(v(mk(4'h6, 3'd1, 3'd2, 6'h2A), 16'h1234, 16'h0, 16'h0, 4'd5, ex(16'h002A, 0, 1, 0, 0, 4'd6)));
    vecs.push_back(v(mk(4'h7, 3'd1, 3'd2, 6'h02), 16'h0004, 16'h0, 16'h0, 4'd7, ex(16'h0, 16'h0006, 1, 1, 0, 4'd8)));
    vecs.push_back(v(mk(4'h7, 3'd1, 3'd2, 6'h20), 16'h0000, 16'h0, 16'h0, 4'd7, ex(16'h0, 16'hFFE0, 1, 1, 0, 4'd8)));
    vecs.push_back(v(mk(4'h8, 3'd1, 3'd2, 6'h3E), 16'h0010, 16'h0, 16'h0, 4'd8, ex(16'h0, 16'h000E, 0, 0, 1, 4'd9)));
    vecs.push_back(v(mk(4'hA, 3'd1, 3'd2, 6'o01), 16'h8001, 16'h0, 16'h0, 4'd9, ex(16'h0002, 0, 1, 0, 0, 4'd10)));
    vecs.push_back(v(mk(4'hB, 3'd1, 3'd2, 6'o01), 16'h8001, 16'h0, 16'h0, 4'd9, ex(16'h4000, 0, 1, 0, 0, 4'd10)));
    vecs.push_back(v(mk(4'hC, 3'd1, 3'd2, 6'o01), 16'h8001, 16'h0, 16'h0, 4'd9, ex(16'hC000, 0, 1, 0, 0, 4'd10)));
    vecs.push_back(v(mk(4'hD, 3'd1, 3'd2, 6'o01), 16'h8001, 16'h0, 16'h0, 4'd9, ex(16'h0003, 0, 1, 0, 0, 4'd10)));
    vecs.push_back(v(mk(4'hC, 3'd1, 3'd2, 6'o07), 16'h7F00, 16'h0, 16'h0, 4'd9, ex(16'h00FE, 0, 1, 0, 0, 4'd10)));
    vecs.push_back(v(mk(4'hD, 3'd1, 3'd2, 6'o00), 16'h1234, 16'h0, 16'h0, 4'd9, ex(16'h1234, 0, 1, 0, 0, 4'd10)));
    vecs.push_back(v(mk(4'hD, 3'd1, 3'd2, 6'o04), 16'h1234, 16'h0, 16'h0, 4'd9, ex(16'h2341, 0, 1, 0, 0, 4'd10)));
    vecs.push_back(v(mk(4'h9, 3'd0, 3'd0, 6'h03), 16'h0, 16'h0, 16'h0, 4'd14, ex(16'h0, 0, 0, 0, 0, 4'd1)));
    vecs.push_back(v(mk(4'hE, 3'd1, 3'd2, 6'h05), 16'h0007, 16'h0, 16'h0007, 4'd14, ex(16'h0, 0, 0, 0, 0, 4'd5)));
    vecs.push_back(v(mk(4'hE, 3'd1, 3'd2, 6'h05), 16'h0007, 16'h0, 16'h0008, 4'd14, ex(16'h0, 0, 0, 0, 0, 4'd15)));
    vecs.push_back(v(mk(4'hF, 3'd1, 3'd2, 6'h05), 16'h0007, 16'h0, 16'h0007, 4'd15, ex(16'h0, 0, 0, 0, 0, 4'd0)));
    vecs.push_back(v(mk(4'hF, 3'd1, 3'd2, 6'h09), 16'h0007, 16'h0, 16'h0008, 4'd2, ex(16'h0, 0, 0, 0, 0, 4'd9)));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      chk_regs($sformatf("vec%0d", i));
    end

    // Reset arriving with an add in flight discards the add.
    @(negedge clk);
    drive(v(mk(4'h0, 3'd1, 3'd2, 6'o30), 16'h0007, 16'h001B, 16'h0, 4'd3, ex(0, 0, 0, 0, 0, 0)));
    reset = 1'b0;
    sb.push_back(ex(16'h0, 16'h0, 0, 0, 0, 4'd0));
    @(posedge clk);
    #1;
    chk_regs("midreset");

    // First edge after release executes normally.
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(ex(16'h0022, 16'h0, 1, 0, 0, 4'd4));
    @(posedge clk);
    #1;
    chk_regs("release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
